// File: rtl/mitchell_acc.sv
// Saturating MAC accumulator for the Mitchell approximate multiplier products.
// Latency: result valid on the edge that accepts the last beat (1 cycle).
// Backpressure: holds the result while acc_ready=0; prod_ready low throughout HOLD.
module mitchell_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_wide;

  // One extra bit catches the carry out so saturation can be detected.
  assign sum_wide = {1'b0, sum_q} + {{(ACC_W - 15){1'b0}}, prod};

  // Next-state and datapath update: accumulate in ACCUM, clear on consume in HOLD.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (prod_valid) begin
          if (sum_wide[ACC_W]) begin
            sum_d = '1;
            ovf_d = 1'b1;
          end else begin
            sum_d = sum_wide[ACC_W-1:0];
          end
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (prod_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and accumulator registers; async reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = (state_q == HOLD);
  assign acc_sum    = sum_q;
  assign acc_count  = cnt_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_mitchell_acc.sv
// Bench for mitchell_acc: two instances (24/8 and 16/2 widths) share one stimulus stream.
// Outputs sampled on the falling edge by the scoreboard and at posedge+1 by literal checks.
// Downstream readiness is driven by the stimulus to exercise HOLD backpressure.
module tb_mitchell_acc;

  logic        clk;
  logic        rst_n;
  logic [15:0] prod;
  logic        prod_valid;
  logic        prod_last;
  logic        acc_ready;

  logic        a_prod_ready, a_acc_ovf, a_acc_valid;
  logic [23:0] a_acc_sum;
  logic [7:0]  a_acc_count;
  logic        b_prod_ready, b_acc_ovf, b_acc_valid;
  logic [15:0] b_acc_sum;
  logic [1:0]  b_acc_count;

  int checks = 0;
  int errors = 0;

  mitchell_acc dut_a (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(a_prod_ready), .acc_sum(a_acc_sum), .acc_count(a_acc_count),
    .acc_ovf(a_acc_ovf), .acc_valid(a_acc_valid), .acc_ready(acc_ready)
  );

  mitchell_acc #(.ACC_W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(b_prod_ready), .acc_sum(b_acc_sum), .acc_count(b_acc_count),
    .acc_ovf(b_acc_ovf), .acc_valid(b_acc_valid), .acc_ready(acc_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded true sum and beat count of the pending vector.
  longint m_true;
  longint m_beats;
  bit     m_hold;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit ovf(input longint v, input int w);
    return v > ((64'sd1 <<< w) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_true  = 0;
      m_beats = 0;
      m_hold  = 1'b0;
    end else if (m_hold) begin
      if (acc_ready) begin
        m_hold  = 1'b0;
        m_true  = 0;
        m_beats = 0;
      end
    end else if (prod_valid) begin
      m_true  = m_true + longint'(prod);
      m_beats = m_beats + 1;
      if (prod_last) m_hold = 1'b1;
    end
  end

  // Scoreboard: handshake every cycle, result fields whenever a result is held.
  always @(negedge clk) begin
    chk("a_prod_ready", a_prod_ready, !m_hold);
    chk("a_acc_valid", a_acc_valid, m_hold);
    chk("b_prod_ready", b_prod_ready, !m_hold);
    chk("b_acc_valid", b_acc_valid, m_hold);
    if (m_hold) begin
      chk("a_acc_sum", a_acc_sum, sat(m_true, 24));
      chk("a_acc_count", a_acc_count, sat(m_beats, 8));
      chk("a_acc_ovf", a_acc_ovf, ovf(m_true, 24));
      chk("b_acc_sum", b_acc_sum, sat(m_true, 16));
      chk("b_acc_count", b_acc_count, sat(m_beats, 2));
      chk("b_acc_ovf", b_acc_ovf, ovf(m_true, 16));
    end
  end

  logic rdy_s;
  always @(negedge clk) rdy_s = a_prod_ready;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (called at posedge+1) and hold it until accepted.
  task automatic beat(input logic [15:0] p, input logic last);
    bit done;
    done = 1'b0;
    prod = p;
    prod_last = last;
    prod_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      done = rdy_s;
      #1;
    end
    chk("beat_accept_timeout", done, 1'b1);
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic lit(input string tag, input logic vld,
                     input logic [23:0] sa, input logic [7:0] ca, input logic oa,
                     input logic [15:0] sb, input logic [1:0] cb, input logic ob);
    chk({tag, "_a_valid"}, a_acc_valid, vld);
    chk({tag, "_a_ready"}, a_prod_ready, !vld);
    chk({tag, "_a_sum"}, a_acc_sum, sa);
    chk({tag, "_a_count"}, a_acc_count, ca);
    chk({tag, "_a_ovf"}, a_acc_ovf, oa);
    chk({tag, "_b_valid"}, b_acc_valid, vld);
    chk({tag, "_b_ready"}, b_prod_ready, !vld);
    chk({tag, "_b_sum"}, b_acc_sum, sb);
    chk({tag, "_b_count"}, b_acc_count, cb);
    chk({tag, "_b_ovf"}, b_acc_ovf, ob);
  endtask

  task automatic after_consume(input string tag);
    chk({tag, "_a_valid_drop"}, a_acc_valid, 1'b0);
    chk({tag, "_a_ready_back"}, a_prod_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    prod = '0;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    acc_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2 lit("reset", 1'b0, 24'h0, 8'h0, 1'b0, 16'h0, 2'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    lit("idle", 1'b0, 24'h0, 8'h0, 1'b0, 16'h0, 2'h0, 1'b0);

    // Back-to-back vector, consumed immediately.
    beat(16'd15, 1'b0);
    beat(16'd35, 1'b0);
    beat(16'hFFFF, 1'b1);
    lit("b2b", 1'b1, 24'h010031, 8'd3, 1'b0, 16'hFFFF, 2'd3, 1'b1);
    step();
    after_consume("b2b");

    // Gapped beats with five cycles of downstream stall.
    acc_ready = 1'b0;
    beat(16'd100, 1'b0);
    step(); step();
    beat(16'd100, 1'b0);
    step();
    beat(16'd100, 1'b0);
    step();
    beat(16'd100, 1'b1);
    lit("gap_hold0", 1'b1, 24'd400, 8'd4, 1'b0, 16'd400, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      lit("gap_hold", 1'b1, 24'd400, 8'd4, 1'b0, 16'd400, 2'd3, 1'b0);
    end
    acc_ready = 1'b1;
    step();
    after_consume("gap");

    // Exactly reaching 0xFFFF does not overflow the 16-bit instance.
    beat(16'hFFFE, 1'b0);
    beat(16'd1, 1'b1);
    lit("sat_exact", 1'b1, 24'h00FFFF, 8'd2, 1'b0, 16'hFFFF, 2'd2, 1'b0);
    step();

    // Exceeding it saturates and sets the sticky flag.
    beat(16'hFFFF, 1'b0);
    beat(16'd1, 1'b0);
    beat(16'd5, 1'b1);
    lit("sat_over", 1'b1, 24'h010005, 8'd3, 1'b0, 16'hFFFF, 2'd3, 1'b1);
    step();

    // Count saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) beat(16'd1, (i == 4));
    lit("cnt_sat", 1'b1, 24'd5, 8'd5, 1'b0, 16'd5, 2'd3, 1'b0);
    step();

    // Reset mid-vector discards the partial sum.
    beat(16'd7, 1'b0);
    beat(16'd7, 1'b0);
    #2 rst_n = 1'b0;
    #1 lit("rst_mid", 1'b0, 24'h0, 8'h0, 1'b0, 16'h0, 2'h0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    beat(16'd9, 1'b1);
    lit("after_rst_mid", 1'b1, 24'd9, 8'd1, 1'b0, 16'd9, 2'd1, 1'b0);
    step();

    // Reset while a result is held.
    acc_ready = 1'b0;
    beat(16'd7, 1'b0);
    beat(16'd7, 1'b1);
    lit("pre_rst_hold", 1'b1, 24'd14, 8'd2, 1'b0, 16'd14, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 lit("rst_hold", 1'b0, 24'h0, 8'h0, 1'b0, 16'h0, 2'h0, 1'b0);
    #1 rst_n = 1'b1;
    acc_ready = 1'b1;
    step();
    beat(16'd9, 1'b1);
    lit("after_rst_hold", 1'b1, 24'd9, 8'd1, 1'b0, 16'd9, 2'd1, 1'b0);
    step();
    after_consume("end");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
